// File: rtl/debounce_arbiter.sv
// Shared-counter switch debouncer: one qualification counter is time-shared across
// all switch channels by a round-robin arbiter, producing stable levels, edge pulses and LEDs.
module debounce_arbiter #(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int CNT_W          = 18,
    localparam int GNT_W         = $clog2(NUM_SW)
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Switch,
    output logic [NUM_SW-1:0] o_Press,
    output logic [NUM_SW-1:0] o_Release,
    output logic [NUM_SW-1:0] o_LED,
    output logic              o_Busy,
    output logic [GNT_W-1:0]  o_Grant
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_SW-1:0]   meta_q, sync_q;
    logic [NUM_SW-1:0]   stable_q, stable_d;
    logic [NUM_SW-1:0]   press_q, press_d;
    logic [NUM_SW-1:0]   release_q, release_d;
    logic [NUM_SW-1:0]   led_q, led_d;
    logic [GNT_W-1:0]    gnt_q, gnt_d;
    logic [GNT_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_SW-1:0]   pending;
    logic                found;
    logic [GNT_W-1:0]    pick;
    logic [GNT_W:0]      rr_sum;
    logic [GNT_W-1:0]    gnt_inc;
    logic                abort;
    logic                done;

    assign pending = sync_q ^ stable_q;
    assign gnt_inc = (gnt_q == GNT_W'(NUM_SW - 1)) ? '0 : gnt_q + 1'b1;

    // A channel that bounced back to its stable level releases the counter at once.
    assign abort = (state_q == S_COUNT) && (sync_q[gnt_q] == stable_q[gnt_q]);
    assign done  = (state_q == S_COUNT) && !abort &&
                   (cnt_q == CNT_W'(DEBOUNCE_LIMIT - 1));

    // First pending channel at or above rr_q, wrapping past NUM_SW-1.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_sum = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            rr_sum = {1'b0, rr_q} + (GNT_W + 1)'(i);
            if (rr_sum >= (GNT_W + 1)'(NUM_SW))
                rr_sum = rr_sum - (GNT_W + 1)'(NUM_SW);
            if (!found && pending[rr_sum[GNT_W-1:0]]) begin
                found = 1'b1;
                pick  = rr_sum[GNT_W-1:0];
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            meta_q    <= '0;
            sync_q    <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            led_q     <= '0;
            gnt_q     <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            meta_q    <= i_Switch;
            sync_q    <= meta_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            led_q     <= led_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found) state_d = S_COUNT;
            S_COUNT: if (abort || done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        led_d     = led_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d = pick;
                    cnt_d = '0;
                end
            end
            S_COUNT: begin
                if (abort) begin
                    cnt_d = '0;
                    rr_d  = gnt_inc;
                end else if (done) begin
                    stable_d[gnt_q] = sync_q[gnt_q];
                    if (sync_q[gnt_q]) begin
                        press_d[gnt_q] = 1'b1;
                    end else begin
                        release_d[gnt_q] = 1'b1;
                        led_d[gnt_q]     = ~led_q[gnt_q];
                    end
                    cnt_d = '0;
                    rr_d  = gnt_inc;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        o_Busy = (state_q == S_COUNT);
    end

    assign o_Switch  = stable_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;
    assign o_LED     = led_q;
    assign o_Grant   = gnt_q;

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter with NUM_SW=4, DEBOUNCE_LIMIT=4.
module tb_debounce_arbiter;

    localparam int NSW = 4;
    localparam int LIM = 4;

    logic           clk = 1'b0;
    logic           rst_l;
    logic [NSW-1:0] sw;
    logic [NSW-1:0] o_switch, o_press, o_release, o_led;
    logic           o_busy;
    logic [1:0]     o_grant;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    debounce_arbiter #(
        .NUM_SW        (NSW),
        .DEBOUNCE_LIMIT(LIM),
        .CNT_W         (3)
    ) dut (
        .i_Clk    (clk),
        .i_Rst_L  (rst_l),
        .i_Switch (sw),
        .o_Switch (o_switch),
        .o_Press  (o_press),
        .o_Release(o_release),
        .o_LED    (o_led),
        .o_Busy   (o_busy),
        .o_Grant  (o_grant)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past n rising edges, landing 1 ns after the last one.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        sw    = '0;
        step(2);
        rst_l = 1'b1;
        step(2);
    endtask

    logic [1:0] glog [16];
    int         ng;
    logic       pb;

    initial begin
        rst_l = 1'b0;
        sw    = 4'b1111;

        // reset state with all switches pressed
        step(3);
        chk("rst_switch",  o_switch,  4'b0000);
        chk("rst_press",   o_press,   4'b0000);
        chk("rst_release", o_release, 4'b0000);
        chk("rst_led",     o_led,     4'b0000);
        chk("rst_busy",    o_busy,    1'b0);
        chk("rst_grant",   o_grant,   2'd0);
        rst_l = 1'b1;
        step(2);
        chk("post_rst_busy_n1", o_busy, 1'b0);
        step(1);
        chk("post_rst_busy_n2",  o_busy,  1'b1);
        chk("post_rst_grant_n2", o_grant, 2'd0);

        // clean press / release on ch1
        do_reset();
        sw = 4'b0010;
        step(2);
        chk("c1_busy_n1", o_busy, 1'b0);
        step(1);
        chk("c1_busy_n2",  o_busy,  1'b1);
        chk("c1_grant_n2", o_grant, 2'd1);
        step(3);
        chk("c1_switch_n5", o_switch, 4'b0000);
        chk("c1_press_n5",  o_press,  4'b0000);
        step(1);
        chk("c1_switch_n6", o_switch, 4'b0010);
        chk("c1_press_n6",  o_press,  4'b0010);
        step(1);
        chk("c1_press_n7", o_press, 4'b0000);
        chk("c1_busy_n7",  o_busy,  1'b0);
        sw = 4'b0000;
        step(7);
        chk("c1_rel_n6",    o_release, 4'b0010);
        chk("c1_rel_sw",    o_switch,  4'b0000);
        chk("c1_rel_led",   o_led,     4'b0010);
        step(1);
        chk("c1_rel_n7",    o_release, 4'b0000);
        chk("c1_led_hold",  o_led,     4'b0010);
        sw = 4'b0010;
        step(7);
        chk("c1_press2", o_press, 4'b0010);
        sw = 4'b0000;
        step(7);
        chk("c1_rel2",  o_release, 4'b0010);
        chk("c1_led2",  o_led,     4'b0000);
        step(1);

        // bounce on ch2: high for three samples then low
        sw = 4'b0100;
        step(3);
        chk("b2_busy_n2",  o_busy,  1'b1);
        chk("b2_grant_n2", o_grant, 2'd2);
        sw = 4'b0000;
        step(2);
        chk("b2_busy_n4",  o_busy,  1'b1);
        chk("b2_press_n4", o_press, 4'b0000);
        step(1);
        chk("b2_busy_n5",   o_busy,   1'b0);
        chk("b2_switch_n5", o_switch, 4'b0000);
        chk("b2_press_n5",  o_press,  4'b0000);

        // simultaneous ch0 + ch3 with pointer at 0, then reversed order
        do_reset();
        sw = 4'b1001;
        step(3);
        chk("s_grant_n2", o_grant, 2'd0);
        step(4);
        chk("s_press_n6",  o_press,  4'b0001);
        chk("s_switch_n6", o_switch, 4'b0001);
        step(1);
        chk("s_press_n7", o_press, 4'b0000);
        chk("s_busy_n7",  o_busy,  1'b1);
        chk("s_grant_n7", o_grant, 2'd3);
        step(4);
        chk("s_press_n11",  o_press,  4'b1000);
        chk("s_switch_n11", o_switch, 4'b1001);
        step(1);
        chk("s_busy_n12", o_busy, 1'b0);
        sw = 4'b1011;
        step(7);
        chk("s_press1", o_press, 4'b0010);
        step(1);
        sw = 4'b0010;
        step(3);
        chk("s_rev_grant3", o_grant, 2'd3);
        step(4);
        chk("s_rev_rel3", o_release, 4'b1000);
        chk("s_rev_led3", o_led,     4'b1000);
        step(1);
        chk("s_rev_grant0", o_grant, 2'd0);
        step(4);
        chk("s_rev_rel0",  o_release, 4'b0001);
        chk("s_rev_led",   o_led,     4'b1001);
        chk("s_rev_sw",    o_switch,  4'b0010);

        // fairness: ch0 and ch1 toggle together every 12 cycles
        do_reset();
        ng = 0;
        pb = o_busy;
        for (int r = 0; r < 4; r++) begin
            sw = (r % 2 == 0) ? 4'b0011 : 4'b0000;
            for (int c = 0; c < 12; c++) begin
                step(1);
                if (o_busy && !pb) begin
                    if (ng < 16) glog[ng] = o_grant;
                    ng++;
                end
                pb = o_busy;
            end
        end
        chk("rr_ngrant", ng, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rr_g%0d", i), {30'd0, glog[i]}, i % 2);
        chk("rr_led",    o_led,    4'b0000);
        chk("rr_switch", o_switch, 4'b0000);

        // reset two cycles into a ch3 qualification
        do_reset();
        sw = 4'b1000;
        step(3);
        chk("m_grant_n2", o_grant, 2'd3);
        step(2);
        rst_l = 1'b0;
        step(1);
        chk("m_busy_rst",   o_busy,   1'b0);
        chk("m_switch_rst", o_switch, 4'b0000);
        chk("m_press_rst",  o_press,  4'b0000);
        step(1);
        rst_l = 1'b1;
        for (int i = 1; i <= LIM + 3; i++) begin
            step(1);
            chk($sformatf("m_press_r%0d", i - 1), o_press, (i == LIM + 3) ? 4'b1000 : 4'b0000);
        end
        chk("m_switch_end", o_switch, 4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/debounce_arbiter.md
Name: debounce_arbiter

Overview:
Shares a single debounce counter among NUM_SW active-high push-switches instead of instantiating one debounce module per switch. Each switch is synchronised, and a round-robin arbiter grants the counter to one switch whose synchronised level differs from its stored stable level. The block then outputs the per-switch debounced levels, single-cycle press/release event pulses, and a per-switch LED toggled on each debounced release. It sits between the board switch pins and the top-level LED logic.

Parameters:
NUM_SW, 4, number of switch channels (2..8)
DEBOUNCE_LIMIT, 250000, cycles a new level must persist before acceptance (10 ms at 25 MHz); must be >= 2
CNT_W, 18, counter width; must satisfy 2**CNT_W > DEBOUNCE_LIMIT

Ports:
i_Clk  input  1  system clock; all logic on rising edge
i_Rst_L  input  1  synchronous active-low reset
i_Switch  input  NUM_SW  raw asynchronous switch pins, 1 = pressed
o_Switch  output  NUM_SW  debounced stable levels
o_Press  output  NUM_SW  1-cycle pulse when stable level goes 0->1
o_Release  output  NUM_SW  1-cycle pulse when stable level goes 1->0
o_LED  output  NUM_SW  per-channel LED, toggled on each o_Release pulse
o_Busy  output  1  1 while the counter is granted (COUNT state)
o_Grant  output  clog2(NUM_SW)  index of the channel currently or last granted

Behaviour:
- Reset (i_Rst_L low at a clock edge) sets all state to 0: sync registers, o_Switch, o_Press, o_Release, o_LED, o_Busy, o_Grant, round-robin pointer rr_ptr, and counter. FSM goes to IDLE. A reset mid-COUNT abandons the qualification with no event.
- Synchroniser: two flops per channel. sync[k] reflects i_Switch[k] two edges after it is first sampled.
- A channel is "pending" when sync[k] != o_Switch[k].
- IDLE state:
  - o_Busy = 0.
  - If any channel is pending, grant the first pending index searching upward from rr_ptr with wrap-around. Set o_Grant to it, clear the counter, and go to COUNT.
  - Otherwise stay in IDLE.
- COUNT state (o_Busy = 1), evaluated each edge for g = o_Grant:
  - Abort: if sync[g] == o_Switch[g] (bounce back), go to IDLE. Counter goes to 0, rr_ptr becomes (g+1) mod NUM_SW, no event.
  - Accept: else if counter == DEBOUNCE_LIMIT-1, set o_Switch[g] to sync[g]. Pulse o_Press[g] or o_Release[g] per direction. On a release, also invert o_LED[g]. rr_ptr becomes (g+1) mod NUM_SW, then go to IDLE.
  - Otherwise increment the counter.
- Latency: if i_Switch[k] holds a new level from sampling edge N and channel k is not blocked, grant occurs at edge N+2. o_Switch[k] updates and the event pulses at edge N+2+DEBOUNCE_LIMIT.
- Event pulses are registered and high exactly one cycle. At most one bit of o_Press | o_Release is set in any cycle.
- Non-granted channels wait and are never lost. A change that occurs and reverts while a channel waits produces no event. The worst-case wait is (NUM_SW-1) x (DEBOUNCE_LIMIT+1) cycles.
- Changes on other channels during COUNT do not affect the granted channel.
- The counter never exceeds DEBOUNCE_LIMIT-1 and has no wrap-around path.

Test Plan:
Use NUM_SW=4 and DEBOUNCE_LIMIT=4 for all scenarios.
1. Reset: hold i_Rst_L=0 for 3 cycles with i_Switch=4'b1111 -> all outputs 0, o_Busy=0. Release reset -> channel 0 granted first (rr_ptr=0).
2. Clean press/release on ch1: i_Switch[1] rises at edge N and is held.
   - o_Grant=1 and o_Busy=1 from edge N+2.
   - o_Switch[1]=1 and one-cycle o_Press[1] at edge N+6.
   - Later release -> o_Release[1] pulse and o_LED[1] 0->1. A second press/release -> o_LED[1] back to 0.
3. Bounce: i_Switch[2] high for 3 cycles then low -> counter granted then aborted. No o_Press, o_Switch[2] stays 0, o_Busy returns 0.
4. Simultaneous: i_Switch = 4'b1001 at the same edge -> ch0 is qualified first (events at N+6), then ch3 is granted (o_Press[3] at N+11). The order reverses when rr_ptr points past 0.
5. Round-robin fairness: ch0 and ch1 toggle continuously at an interval longer than the limit -> grants alternate 0,1,0,1 and neither channel is starved.
6. Reset mid-COUNT: assert i_Rst_L=0 two cycles into a ch3 qualification -> no event, o_Switch=0. After reset, ch3 (still pressed) is requalified from scratch and o_Press[3] fires LIMIT+2 cycles after reset release.
